tube_scan: RTL and testbench

Seven-segment ("tube") scan driver. It sits directly downstream of the tube clock divider and consumes its divided clock as a scan-rate strobe. Each strobe multiplexes the next digit of an 8-digit display. A short blanking gap between digits suppresses ghosting, and data is snapshotted per frame so a digit never tears mid-frame.

---
 rtl/tube_pkg.sv | 26 ++
 rtl/tube_seg_decode.sv | 12 +
 rtl/tube_scan.sv | 151 +++++++++++++++
 tb/tb_tube_scan.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tube_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment patterns are kept active-high; polarity is applied only at the outputs.
package tube_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam int DIGITS_MAX = 8;
    localparam int IDX_W      = $clog2(DIGITS_MAX);

    localparam logic [7:0] SEG_OFF = 8'h00;

    // gfedcba for nibbles F..0; entry 0 sits in the least-significant 7 bits
    localparam logic [16*7-1:0] HEX_SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG_TABLE[int'(nibble) * 7 +: 7];
    endfunction

endpackage

// File: rtl/tube_seg_decode.sv
// Hex nibble plus decimal point to active-high {dp,g,f,e,d,c,b,a} pattern.
module tube_seg_decode
    import tube_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    assign seg = {dp, hex_to_seg(nibble)};

endmodule

// File: rtl/tube_scan.sv
// Multiplexed 7-segment scan driver with inter-digit blanking and per-frame data snapshot.
// Optional build macro TUBE_LZ_BLANK_EN enables leading-zero blanking at snapshot time.
//
// state | meaning
// IDLE  | outputs dark, waiting for the first scan strobe
// BLANK | all lines inactive for BLANK_CYCLES clk before the next digit
// SHOW  | current digit driven until the next scan strobe
module tube_scan
    import tube_pkg::*;
#(
    parameter int DIGITS         = 8,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scan_clk,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     digit_en,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     sel,
    output logic                  frame_done
);

    localparam int CNT_W = (BLANK_CYCLES < 2) ? 1 : $clog2(BLANK_CYCLES);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [7:0]        SEG_POL  = {8{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] SEL_POL  = {DIGITS{SEL_ACTIVE_LOW}};

    logic                  scan_q;
    logic                  tick;
    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [CNT_W-1:0]      cnt;
    logic [4*DIGITS-1:0]   snap_data;
    logic [DIGITS-1:0]     snap_dp;
    logic [DIGITS-1:0]     snap_en;
    logic [DIGITS-1:0]     lz_mask;
    logic [3:0]            cur_nibble;
    logic                  cur_dp;
    logic                  cur_on;
    logic [7:0]            dec_seg;
    logic [7:0]            seg_next;
    logic [DIGITS-1:0]     sel_next;

    // scan_clk already lives in the clk domain, so one flop is enough for edge detect
    always_ff @(posedge clk) begin
        scan_q <= scan_clk;
    end

    assign tick = scan_clk & ~scan_q;

`ifdef TUBE_LZ_BLANK_EN
    logic lz_seen;

    // Scan from the top nibble down; everything at or below the first nonzero stays eligible
    always_comb begin
        lz_seen = 1'b0;
        lz_mask = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (data[4*i +: 4] != 4'h0) begin
                lz_seen = 1'b1;
            end
            lz_mask[i] = lz_seen | dp[i] | (i == 0);
        end
    end
`else
    assign lz_mask = '1;
`endif

    assign cur_nibble = snap_data[{idx, 2'b00} +: 4];
    assign cur_dp     = snap_dp[idx];
    assign cur_on     = (state == SHOW) && snap_en[idx];

    tube_seg_decode u_decode (
        .nibble (cur_nibble),
        .dp     (cur_dp),
        .seg    (dec_seg)
    );

    always_comb begin
        seg_next = SEG_OFF ^ SEG_POL;
        sel_next = SEL_POL;
        if (cur_on) begin
            seg_next = dec_seg ^ SEG_POL;
            sel_next = (DIGITS'(1) << idx) ^ SEL_POL;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            snap_data  <= '0;
            snap_dp    <= '0;
            snap_en    <= '0;
            frame_done <= 1'b0;
            seg        <= SEG_OFF ^ SEG_POL;
            sel        <= SEL_POL;
        end else begin
            seg        <= seg_next;
            sel        <= sel_next;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        snap_data <= data;
                        snap_dp   <= dp;
                        snap_en   <= digit_en & lz_mask;
                        idx       <= '0;
                        cnt       <= '0;
                        state     <= BLANK;
                    end
                end
                BLANK: begin
                    // strobes landing here are dropped; blanking is shorter than a scan period
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= SHOW;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (tick) begin
                        cnt   <= '0;
                        state <= BLANK;
                        if (idx == IDX_LAST) begin
                            idx        <= '0;
                            snap_data  <= data;
                            snap_dp    <= dp;
                            snap_en    <= digit_en & lz_mask;
                            frame_done <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tube_scan.sv
// Directed bench for tube_scan: reset, scan order, frame wrap, masking/dp, mid-scan reset, hold, leading zeros.
module tb_tube_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scan_clk = 1'b0;
    logic [31:0] data = '0;
    logic [7:0]  dp = '0;
    logic [7:0]  digit_en = '0;
    logic [7:0]  seg;
    logic [7:0]  sel;
    logic        frame_done;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] obs_seg;
    logic [7:0] obs_sel;
    int         obs_fd;
    int         obs_gap_bad;

    always #5 clk = ~clk;

    tube_scan #(
        .DIGITS         (8),
        .BLANK_CYCLES   (16),
        .SEG_ACTIVE_LOW (1'b1),
        .SEL_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_clk   (scan_clk),
        .data       (data),
        .dp         (dp),
        .digit_en   (digit_en),
        .seg        (seg),
        .sel        (sel),
        .frame_done (frame_done)
    );

    // Independent reference: active-low segment lines for a nibble and dp bit
    function automatic logic [7:0] exp_seg(input logic [3:0] n, input logic d);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
            4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
            4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
            4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  default: p = 7'h71;
        endcase
        return ~{d, p};
    endfunction

    function automatic logic [7:0] exp_sel(input int i);
        logic [7:0] oh;
        oh = 8'h01 << i;
        return ~oh;
    endfunction

    // One scan step: strobe, then watch the 16-clk blank gap, then capture the lit digit
    task automatic scan_step();
        @(negedge clk);
        scan_clk = 1'b1;
        @(negedge clk);
        scan_clk = 1'b0;
        obs_fd = int'(frame_done);
        obs_gap_bad = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (sel !== 8'hFF || seg !== 8'hFF) obs_gap_bad++;
            obs_fd += int'(frame_done);
        end
        @(negedge clk);
        obs_seg = seg;
        obs_sel = sel;
        obs_fd += int'(frame_done);
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            scan_clk = ~scan_clk;
            @(negedge clk);
            tests_run++;
            if (seg !== 8'hFF || sel !== 8'hFF || frame_done !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_hold cyc%0d: seg=%h sel=%h fd=%b, want seg=ff sel=ff fd=0", k, seg, sel, frame_done);
            end
        end
        scan_clk = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (seg !== 8'hFF || sel !== 8'hFF || frame_done !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL reset_idle: %0d lit cycles before first strobe, want 0", bad);
        end
    endtask

    task automatic test_scan_order();
        data = 32'h76543210;
        dp = 8'h00;
        digit_en = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            scan_step();
            tests_run++;
            if (obs_sel !== exp_sel(i) || obs_seg !== exp_seg(4'(i), 1'b0)) begin
                tests_failed++;
                $display("FAIL scan_order idx%0d: sel=%h seg=%h, want sel=%h seg=%h",
                         i, obs_sel, obs_seg, exp_sel(i), exp_seg(4'(i), 1'b0));
            end
            tests_run++;
            if (obs_gap_bad != 0 || obs_fd != 0) begin
                tests_failed++;
                $display("FAIL scan_gap idx%0d: lit_in_gap=%0d fd=%0d, want 0 and 0", i, obs_gap_bad, obs_fd);
            end
        end
    endtask

    task automatic test_frame_wrap();
        scan_step();
        tests_run++;
        if (obs_fd != 1 || obs_sel !== 8'hFE || obs_seg !== 8'hC0) begin
            tests_failed++;
            $display("FAIL wrap_first: fd=%0d sel=%h seg=%h, want fd=1 sel=fe seg=c0", obs_fd, obs_sel, obs_seg);
        end
        data = 32'hFFFFFFFF;
        for (int i = 1; i < 8; i++) begin
            scan_step();
            tests_run++;
            if (obs_seg !== exp_seg(4'(i), 1'b0) || obs_sel !== exp_sel(i) || obs_fd != 0) begin
                tests_failed++;
                $display("FAIL wrap_snapshot idx%0d: seg=%h sel=%h fd=%0d, want seg=%h sel=%h fd=0",
                         i, obs_seg, obs_sel, obs_fd, exp_seg(4'(i), 1'b0), exp_sel(i));
            end
        end
        scan_step();
        tests_run++;
        if (obs_fd != 1 || obs_sel !== 8'hFE || obs_seg !== 8'h8E) begin
            tests_failed++;
            $display("FAIL wrap_new_data: fd=%0d sel=%h seg=%h, want fd=1 sel=fe seg=8e", obs_fd, obs_sel, obs_seg);
        end
    endtask

    task automatic test_mask_dp();
        logic [7:0] want_seg;
        logic [7:0] want_sel;
        for (int i = 1; i < 8; i++) scan_step();
        digit_en = 8'h05;
        dp = 8'h04;
        data = 32'h00000A08;
        for (int i = 0; i < 8; i++) begin
            scan_step();
            case (i)
                0:       begin want_sel = 8'hFE; want_seg = 8'h80; end
                2:       begin want_sel = 8'hFB; want_seg = 8'h08; end
                default: begin want_sel = 8'hFF; want_seg = 8'hFF; end
            endcase
            tests_run++;
            if (obs_sel !== want_sel || obs_seg !== want_seg) begin
                tests_failed++;
                $display("FAIL mask_dp idx%0d: sel=%h seg=%h, want sel=%h seg=%h", i, obs_sel, obs_seg, want_sel, want_seg);
            end
        end
    endtask

    task automatic test_mid_reset();
        int bad;
        data = 32'h76543210;
        dp = 8'h00;
        digit_en = 8'hFF;
        for (int i = 0; i < 6; i++) scan_step();
        tests_run++;
        if (obs_sel !== 8'hDF || obs_seg !== 8'h92) begin
            tests_failed++;
            $display("FAIL mid_reset_pre idx5: sel=%h seg=%h, want sel=df seg=92", obs_sel, obs_seg);
        end
        data = 32'h89ABCDEF;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tests_run++;
        if (seg !== 8'hFF || sel !== 8'hFF || frame_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_dark: seg=%h sel=%h fd=%b, want ff ff 0", seg, sel, frame_done);
        end
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (seg !== 8'hFF || sel !== 8'hFF) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL mid_reset_idle: %0d lit cycles after reset, want 0", bad);
        end
        scan_step();
        tests_run++;
        if (obs_sel !== 8'hFE || obs_seg !== 8'h8E) begin
            tests_failed++;
            $display("FAIL mid_reset_restart idx0: sel=%h seg=%h, want sel=fe seg=8e", obs_sel, obs_seg);
        end
        scan_step();
        tests_run++;
        if (obs_sel !== 8'hFD || obs_seg !== 8'h86) begin
            tests_failed++;
            $display("FAIL mid_reset_restart idx1: sel=%h seg=%h, want sel=fd seg=86", obs_sel, obs_seg);
        end
    endtask

    task automatic test_hold();
        int changes;
        changes = 0;
        scan_clk = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (sel !== 8'hFD || seg !== 8'h86 || frame_done !== 1'b0) changes++;
        end
        tests_run++;
        if (changes != 0) begin
            tests_failed++;
            $display("FAIL hold_steady: %0d cycles off the held digit, want 0", changes);
        end
    endtask

    task automatic test_leading_zero();
        logic [7:0] want_seg;
        logic [7:0] want_sel;
        logic [31:0] pat;
        bit lit;
        for (int i = 2; i < 8; i++) scan_step();
        for (int f = 0; f < 2; f++) begin
            pat = (f == 0) ? 32'h00000120 : 32'h00000000;
            data = pat;
            dp = 8'h00;
            digit_en = 8'hFF;
            for (int i = 0; i < 8; i++) begin
                scan_step();
`ifdef TUBE_LZ_BLANK_EN
                lit = (f == 0) ? (i <= 2) : (i == 0);
`else
                lit = 1'b1;
`endif
                want_sel = lit ? exp_sel(i) : 8'hFF;
                want_seg = lit ? exp_seg(pat[4*i +: 4], 1'b0) : 8'hFF;
                tests_run++;
                if (obs_sel !== want_sel || obs_seg !== want_seg) begin
                    tests_failed++;
                    $display("FAIL leading_zero data=%h idx%0d: sel=%h seg=%h, want sel=%h seg=%h",
                             pat, i, obs_sel, obs_seg, want_sel, want_seg);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_frame_wrap();
        test_mask_dp();
        test_mid_reset();
        test_hold();
        test_leading_zero();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
